// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generation array and its sequencer.
//
// Contents:
//   NSQ_BOARD / SQW_BOARD  default square count and square-index width
//   piece_type_t / piece_t 4-bit piece code: bit 3 colour, bits 2:0 type, 0 = empty
//   sq_t                   square index
//   seq_state_t + ST_*     sequencer state encoding
package movegen_pkg;

    localparam int unsigned NSQ_BOARD = 64;
    localparam int unsigned SQW_BOARD = 6;

    typedef enum logic [2:0] {
        PT_EMPTY  = 3'd0,
        PT_PAWN   = 3'd1,
        PT_KNIGHT = 3'd2,
        PT_BISHOP = 3'd3,
        PT_ROOK   = 3'd4,
        PT_QUEEN  = 3'd5,
        PT_KING   = 3'd6
    } piece_type_t;

    typedef struct packed {
        logic        colour;
        piece_type_t ptype;
    } piece_t;

    typedef logic [SQW_BOARD-1:0] sq_t;

    // Sequencer states, kept as plain constants so older tools can share the encoding.
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_LOAD  = 3'd1;
    localparam seq_state_t ST_ISSUE = 3'd2;
    localparam seq_state_t ST_WAIT  = 3'd3;
    localparam seq_state_t ST_DRAIN = 3'd4;
    localparam seq_state_t ST_DONE  = 3'd5;

    function automatic logic piece_is_empty(input piece_t p);
        return p.ptype == PT_EMPTY;
    endfunction

endpackage

// File: rtl/movegen_sequencer_if.sv
// Bundle of every non-clock/reset signal of the move-generation sequencer.
//
// Groups:
//   command   start, busy, done
//   position  pos_in_valid, pos_in_ready, pos_in_data (square NSQ-1 first)
//   array     chain_valid, chain_data, src_sel, emit_move, target_mask
//   moves     move_valid, move_ready, move_from, move_to, move_count
//
// Modports:
//   master  the sequencer itself
//   slave   host, array and move consumer as seen from the other side
interface movegen_sequencer_if
    import movegen_pkg::*;
#(
    parameter int unsigned NSQ  = NSQ_BOARD,
    parameter int unsigned SQW  = SQW_BOARD,
    parameter int unsigned CNTW = 8
);

    logic            start;
    logic            busy;
    logic            done;

    logic            pos_in_valid;
    logic            pos_in_ready;
    piece_t          pos_in_data;

    logic            chain_valid;
    piece_t          chain_data;
    logic [NSQ-1:0]  src_sel;
    logic            emit_move;
    logic [NSQ-1:0]  target_mask;

    logic            move_valid;
    logic            move_ready;
    logic [SQW-1:0]  move_from;
    logic [SQW-1:0]  move_to;
    logic [CNTW-1:0] move_count;

    modport master (
        input  start,
        output busy,
        output done,
        input  pos_in_valid,
        output pos_in_ready,
        input  pos_in_data,
        output chain_valid,
        output chain_data,
        output src_sel,
        output emit_move,
        input  target_mask,
        output move_valid,
        input  move_ready,
        output move_from,
        output move_to,
        output move_count
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        output pos_in_valid,
        input  pos_in_ready,
        output pos_in_data,
        input  chain_valid,
        input  chain_data,
        input  src_sel,
        input  emit_move,
        output target_mask,
        input  move_valid,
        output move_ready,
        input  move_from,
        input  move_to,
        input  move_count
    );

endinterface

// File: rtl/movegen_prienc.sv
// Lowest-set-bit priority encoder.
//
// Ports:
//   vec  input  N   request vector
//   idx  output W   index of the lowest set bit of vec (0 when vec is zero)
//   any  output 1   vec has at least one bit set
module movegen_prienc #(
    parameter int unsigned N = 64,
    parameter int unsigned W = 6
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Scan high to low so the last hit, the lowest index, wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/movegen_sequencer.sv
// Controller for the 64-square move-generation array.
//
// Loads a board position into the array's piece shift chain, then walks every origin
// square: selects it, pulses emit_move, captures the returned target mask MASK_LAT
// cycles later and serialises each set bit, lowest first, as a (from,to) move on a
// valid/ready output.
//
// Ports:
//   clk  input  clock, everything on the rising edge
//   rst  input  synchronous active-high reset; aborts any run without a done pulse
//   bus  master side of movegen_sequencer_if:
//        start/busy/done                      command handshake
//        pos_in_valid/pos_in_ready/pos_in_data  host position stream
//        chain_valid/chain_data               shift chain head of the array
//        src_sel/emit_move/target_mask        origin select, emit strobe, returned targets
//        move_valid/move_ready/move_from/move_to  move stream
//        move_count                           moves emitted this scan, saturating
module movegen_sequencer
    import movegen_pkg::*;
#(
    parameter int unsigned NSQ      = NSQ_BOARD,
    parameter int unsigned SQW      = SQW_BOARD,
    parameter int unsigned MASK_LAT = 2,
    parameter int unsigned CNTW     = 8
) (
    input  logic clk,
    input  logic rst,
    movegen_sequencer_if.master bus
);

    localparam int unsigned LATW = $clog2(MASK_LAT + 1);

    seq_state_t      state_q, state_d;
    logic [SQW-1:0]  beat_q, beat_d;
    logic [SQW-1:0]  src_q, src_d;
    logic [LATW-1:0] wait_q, wait_d;
    logic [NSQ-1:0]  pending_q, pending_d;
    logic [CNTW-1:0] move_count_q, move_count_d;

    logic            chain_valid_q, chain_valid_d;
    piece_t          chain_data_q, chain_data_d;

    logic            move_valid_q, move_valid_d;
    logic [SQW-1:0]  move_from_q, move_from_d;
    logic [SQW-1:0]  move_to_q, move_to_d;

    logic            pos_accept;
    logic            src_active;
    logic [SQW-1:0]  enc_idx;
    logic            enc_any;

    assign pos_accept = (state_q == ST_LOAD) && bus.pos_in_valid;
    assign src_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                        (state_q == ST_DRAIN);

    // Next-state control.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        src_d        = src_q;
        wait_d       = wait_q;
        pending_d    = pending_q;
        move_count_d = move_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_LOAD;
                    beat_d       = '0;
                    move_count_d = '0;
                end
            end

            ST_LOAD: begin
                if (pos_accept) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == SQW'(NSQ - 1)) begin
                        state_d = ST_ISSUE;
                        src_d   = '0;
                    end
                end
            end

            ST_ISSUE: begin
                wait_d  = LATW'(MASK_LAT);
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                wait_d = wait_q - 1'b1;
                if (wait_q == LATW'(1)) begin
                    pending_d = bus.target_mask;
                    state_d   = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (pending_q == '0) begin
                    if (src_q == SQW'(NSQ - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        src_d   = src_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (bus.move_ready) begin
                    // The presented move is always the lowest pending bit, so this clears it.
                    pending_d = pending_q & (pending_q - 1'b1);
                    if (move_count_q != '1) begin
                        move_count_d = move_count_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The encoder looks at next-cycle pending so the registered move outputs line up
    // with the bit they describe, keeping one move per cycle under sustained ready.
    movegen_prienc #(
        .N (NSQ),
        .W (SQW)
    ) u_prienc (
        .vec (pending_d),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        move_valid_d  = (state_d == ST_DRAIN) && enc_any;
        move_from_d   = move_valid_d ? src_q : move_from_q;
        move_to_d     = move_valid_d ? enc_idx : move_to_q;
        chain_valid_d = pos_accept;
        chain_data_d  = pos_accept ? bus.pos_in_data : chain_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            src_q         <= '0;
            wait_q        <= '0;
            pending_q     <= '0;
            move_count_q  <= '0;
            chain_valid_q <= 1'b0;
            chain_data_q  <= '0;
            move_valid_q  <= 1'b0;
            move_from_q   <= '0;
            move_to_q     <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            src_q         <= src_d;
            wait_q        <= wait_d;
            pending_q     <= pending_d;
            move_count_q  <= move_count_d;
            chain_valid_q <= chain_valid_d;
            chain_data_q  <= chain_data_d;
            move_valid_q  <= move_valid_d;
            move_from_q   <= move_from_d;
            move_to_q     <= move_to_d;
        end
    end

    assign bus.busy         = (state_q == ST_LOAD) || src_active;
    assign bus.done         = (state_q == ST_DONE);
    assign bus.pos_in_ready = (state_q == ST_LOAD);
    assign bus.emit_move    = (state_q == ST_ISSUE);
    assign bus.src_sel      = src_active ? (NSQ'(1) << src_q) : '0;
    assign bus.chain_valid  = chain_valid_q;
    assign bus.chain_data   = chain_data_q;
    assign bus.move_valid   = move_valid_q;
    assign bus.move_from    = move_from_q;
    assign bus.move_to      = move_to_q;
    assign bus.move_count   = move_count_q;

endmodule

// File: tb/tb_movegen_sequencer.sv
// Directed self-checking bench for movegen_sequencer with a small array model that
// returns a target mask exactly MASK_LAT cycles after each emit pulse.
module tb_movegen_sequencer;
    import movegen_pkg::*;

    localparam int unsigned NSQ      = 64;
    localparam int unsigned SQW      = 6;
    localparam int unsigned MASK_LAT = 2;
    localparam int unsigned CNTW     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    movegen_sequencer_if #(.NSQ(NSQ), .SQW(SQW), .CNTW(CNTW)) bus ();

    movegen_sequencer #(
        .NSQ      (NSQ),
        .SQW      (SQW),
        .MASK_LAT (MASK_LAT),
        .CNTW     (CNTW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    // Array model: 0 = empty board, 1 = only square 1 targets 8 and 10, 2 = all ones.
    int mode    = 0;
    int lat_cnt = 0;
    int cur_src = 0;

    function automatic int onehot_idx(input logic [NSQ-1:0] v);
        int r = 0;
        for (int i = 0; i < NSQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            lat_cnt <= 0;
        end else if (bus.emit_move) begin
            cur_src <= onehot_idx(bus.src_sel);
            lat_cnt <= MASK_LAT;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
        end
    end

    // Outside the valid window the model returns junk, so a mistimed capture shows up.
    always_comb begin
        bus.target_mask = 64'hDEAD_BEEF_0F0F_F0F0;
        if (lat_cnt == 1) begin
            case (mode)
                0:       bus.target_mask = '0;
                1:       bus.target_mask = (cur_src == 1) ? 64'h0000_0000_0000_0500 : '0;
                default: bus.target_mask = '1;
            endcase
        end
    end

    // Monitor: accepted moves, done pulses and chain beats.
    logic [11:0] mv_q[$];
    int          mv_cyc[$];
    int          cyc       = 0;
    int          done_cnt  = 0;
    int          chain_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.move_valid && bus.move_ready) begin
            mv_q.push_back({bus.move_from, bus.move_to});
            mv_cyc.push_back(cyc);
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.chain_valid) chain_cnt <= chain_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {bus.busy, bus.done, bus.pos_in_ready, bus.chain_valid,
                              bus.emit_move, bus.move_valid}, '0);
        check({tag, "_src_sel"}, bus.src_sel, '0);
        check({tag, "_chain_data"}, bus.chain_data, '0);
        check({tag, "_move_from_to"}, {bus.move_from, bus.move_to}, '0);
        check({tag, "_move_count"}, bus.move_count, '0);
    endtask

    // Start a run and stream 64 beats (data = beat mod 16) with valid held high.
    task automatic run_load(input string tag);
        int chain_err = 0;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.pos_in_valid = 1'b1;
        bus.pos_in_data  = '0;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy_rise"}, bus.busy, 1'b1);
        check({tag, "_ready_load"}, bus.pos_in_ready, 1'b1);
        for (int b = 0; b < 64; b++) begin
            bus.pos_in_data = 4'(b);
            @(negedge clk);
            if (!(bus.chain_valid === 1'b1 && bus.chain_data === 4'(b))) chain_err++;
        end
        bus.pos_in_valid = 1'b0;
        check({tag, "_chain_seq_errs"}, chain_err, 0);
        check({tag, "_ready_drop"}, bus.pos_in_ready, 1'b0);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", n < limit, 1'b1);
    endtask

    task automatic wait_move(input int limit);
        int n = 0;
        while (bus.move_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("move_within_budget", n < limit, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int base_done;
        int base_chain;
        int order_err;

        bus.start        = 1'b0;
        bus.pos_in_valid = 1'b0;
        bus.pos_in_data  = '0;
        bus.move_ready   = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Scenarios 1+2: load, then an empty-board scan.
        mode       = 0;
        base       = mv_q.size();
        base_done  = done_cnt;
        base_chain = chain_cnt;
        run_load("load0");
        wait_done(2000, n);
        check("empty_done_cycle", 64 + n, 64 + 64 * (MASK_LAT + 2));
        check("done_busy_low", bus.busy, 1'b0);
        check("done_src_sel_zero", bus.src_sel, '0);
        @(negedge clk);
        check("done_single_pulse", bus.done, 1'b0);
        check("empty_done_count", done_cnt - base_done, 1);
        check("chain_valid_cycles", chain_cnt - base_chain, 64);
        check("empty_moves", mv_q.size() - base, 0);
        check("empty_move_count", bus.move_count, 0);

        // Scenario 3: two moves from square 1 with ready held high.
        mode = 1;
        base = mv_q.size();
        run_load("load1");
        wait_done(2000, n);
        @(negedge clk);
        check("s3_num_moves", mv_q.size() - base, 2);
        if (mv_q.size() - base == 2) begin
            check("s3_move0", mv_q[base], {6'd1, 6'd8});
            check("s3_move1", mv_q[base+1], {6'd1, 6'd10});
            check("s3_back_to_back", mv_cyc[base+1] - mv_cyc[base], 1);
        end
        check("s3_move_count", bus.move_count, 2);

        // Scenario 4: ready low for 5 cycles on the first move.
        mode           = 1;
        bus.move_ready = 1'b0;
        base           = mv_q.size();
        run_load("load2");
        wait_move(1000);
        for (int i = 0; i < 5; i++) begin
            check("s4_hold", {bus.move_valid, bus.move_from, bus.move_to},
                  {1'b1, 6'd1, 6'd8});
            @(negedge clk);
        end
        bus.move_ready = 1'b1;
        wait_done(2000, n);
        @(negedge clk);
        check("s4_num_moves", mv_q.size() - base, 2);
        if (mv_q.size() - base == 2) begin
            check("s4_move0", mv_q[base], {6'd1, 6'd8});
            check("s4_move1", mv_q[base+1], {6'd1, 6'd10});
        end
        check("s4_move_count", bus.move_count, 2);

        // Scenario 5: every square targets every square.
        mode = 2;
        base = mv_q.size();
        run_load("load3");
        wait_done(20000, n);
        @(negedge clk);
        check("s5_num_moves", mv_q.size() - base, 4096);
        order_err = 0;
        if (mv_q.size() - base == 4096) begin
            for (int i = 0; i < 4096; i++) begin
                if (mv_q[base+i] !== {6'(i / 64), 6'(i % 64)}) order_err++;
            end
        end
        check("s5_order_errs", order_err, 0);
        check("s5_move_count_sat", bus.move_count, 255);

        // Scenario 6: start ignored mid-scan, then reset during DRAIN, then restart.
        mode           = 2;
        bus.move_ready = 1'b0;
        run_load("load4");
        wait_move(1000);
        check("s6_self_target", {bus.move_from, bus.move_to}, {6'd0, 6'd0});
        bus.move_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.move_ready = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("s6_start_ignored_busy", {bus.busy, bus.pos_in_ready}, 2'b10);
        check("s6_start_ignored_count", bus.move_count, 3);
        check("s6_start_ignored_move", {bus.move_valid, bus.move_from, bus.move_to},
              {1'b1, 6'd0, 6'd3});
        base_done = done_cnt;
        rst       = 1'b1;
        @(negedge clk);
        check_reset_outputs("s6_mid_reset");
        rst = 1'b0;
        @(negedge clk);
        check("s6_no_done_on_reset", done_cnt - base_done, 0);
        mode           = 1;
        bus.move_ready = 1'b1;
        base           = mv_q.size();
        run_load("load5");
        wait_done(2000, n);
        @(negedge clk);
        check("s6_restart_done", done_cnt - base_done, 1);
        check("s6_restart_moves", mv_q.size() - base, 2);
        if (mv_q.size() - base == 2) begin
            check("s6_restart_move1", mv_q[base+1], {6'd1, 6'd10});
        end
        check("s6_restart_count", bus.move_count, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/movegen_sequencer.md
Name: movegen_sequencer

Overview:
- Controller for the 64-square move-generation array.
- Streams a 64-square board position into the array's piece shift chain.
- Walks every origin square: selects it, fires an emit pulse, captures the target-square mask the array returns, and serialises each set bit into a (from,to) move on a valid/ready output.
- Sits between the host position/command interface and the array of per-square cells.

Parameters:
NSQ, 64, number of squares in the array (power of two, >=4)
SQW, 6, square index width, equal to log2(NSQ)
MASK_LAT, 2, cycles from emit_move assertion to valid target_mask (>=1)
CNTW, 8, move counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle command: begin load + scan; ignored unless IDLE
busy  output  1  high from accepted start until done pulse
done  output  1  one-cycle pulse at end of scan
pos_in_valid  input  1  host position beat valid
pos_in_ready  output  1  high only in LOAD
pos_in_data  input  4  piece code, square NSQ-1 first, square 0 last
chain_valid  output  1  shift-enable to array chain head (in_pos_valid of first cell)
chain_data  output  4  piece code to chain head
src_sel  output  NSQ  one-hot origin square select, zero outside scan
emit_move  output  1  one-cycle pulse to array per origin square
target_mask  input  NSQ  per-square target bits from array
move_valid  output  1  move available
move_ready  input  1  consumer accepts move
move_from  output  SQW  origin square index
move_to  output  SQW  target square index
move_count  output  CNTW  moves emitted this scan, saturating

Behaviour:
- Reset: state IDLE; busy, done, pos_in_ready, chain_valid, emit_move, move_valid = 0; chain_data, src_sel, move_from, move_to, move_count = 0. Reset mid-operation aborts immediately, with no done pulse. The array contents are left undefined and are reloaded on the next start.
- IDLE: on start, clear move_count, beat counter = 0, go to LOAD. busy rises the cycle after start.
- LOAD:
  - pos_in_ready = 1. chain_valid and chain_data register pos_in_valid and pos_in_data, so the chain sees each beat 1 cycle after acceptance.
  - Beat counter increments per accepted beat (valid && ready).
  - After beat NSQ-1 is accepted, go to ISSUE with src = 0.
  - Stalls (valid low) hold the chain: chain_valid = 0.
- ISSUE:
  - src_sel = one-hot(src). emit_move = 1 for exactly this cycle.
  - Wait counter = MASK_LAT. Go to WAIT.
  - src_sel is held through WAIT and DRAIN.
- WAIT: decrement the counter. When it reaches 0, capture target_mask into a pending register and go to DRAIN.
- DRAIN:
  - If pending == 0, advance.
  - Else present move_from = src and move_to = index of the lowest set bit of pending, with move_valid = 1.
  - Outputs are registered and stable while move_valid && !move_ready.
  - On handshake: clear that bit, increment move_count (saturating at 2^CNTW-1). The next move is presented the following cycle, giving at most 1 move/cycle with sustained ready.
  - Advance: if src == NSQ-1, go to DONE; else src++ and go to ISSUE.
- DONE: src_sel = 0, pulse done for 1 cycle, drop busy in the same cycle, go to IDLE. move_count is held until the next accepted start.
- start while busy: ignored.
- Self-target bit (mask bit == src) is treated as an ordinary bit. Filtering belongs to the array.
- Empty board (all masks zero): scan takes NSQ*(MASK_LAT+2) cycles after LOAD and emits no moves; done still pulses.
- Priority encoder: lowest-index first, purely combinational on pending, with registered outputs.

Decomposition:
- Shared package movegen_pkg:
  - piece code typedef (4-bit: 0 = empty, colour bit 3, type bits 2:0)
  - square index typedef
  - NSQ/SQW constants
  - sequencer state enum (IDLE, LOAD, ISSUE, WAIT, DRAIN, DONE)
- Sub-module movegen_prienc: parameterised NSQ-bit lowest-set-bit encoder with an index output and an any flag. It is reused by later move-ordering logic.

Test Plan:
1. Reset, then start, then 64 beats with valid held high and data = beat index mod 16 -> chain_valid high for exactly 64 cycles, chain_data sequence matches 1 cycle delayed; pos_in_ready drops after the 64th beat.
2. Scan with the model returning target_mask = 0 for all squares -> no move_valid, done pulses once at (64 load cycles)+64*(MASK_LAT+2), move_count = 0.
3. Model returns mask 0x0000_0000_0000_0500 only for src 1, with ready held high -> moves (1,8) then (1,10) on consecutive cycles, move_count = 2.
4. Same as scenario 3 but ready low for 5 cycles at the first move -> move_from/move_to hold (1,8) stable for all 5 cycles; no move is lost or duplicated.
5. Every square returns all-ones -> 4096 moves, lowest-to-highest order per src, move_count saturates at 255.
6. rst asserted in the middle of DRAIN, then a fresh start issued -> outputs return to reset values on the next edge, no done pulse; the restarted run completes normally. Start pulsed during scan -> ignored.
